// File: rtl/fft_frame_buffer.sv
// ---------------------------------------------------------------------------
// fft_frame_buffer
//
// Ping-pong input framer for the FFT pipeline. Signed samples arrive one per
// cycle on a valid/ready stream and are collected into N_POINTS-sample
// frames. A finished frame is presented whole on FRAME_DATA and handed to the
// FFT core with a frame-level valid/ready handshake. While the core holds one
// bank, the other bank fills. With BIT_REV=1, samples are stored in
// bit-reversed slot order so that a decimation-in-time core can take the
// frame directly.
//
// Ports
//   CLK          rising-edge clock
//   RST_N        asynchronous active-low reset; clears control and storage
//   IN_VALID     input sample valid
//   IN_READY     high while the current write bank is not full
//   IN_DATA      signed sample, DATA_W bits
//   IN_LAST      frame-end marker. It is optional on the last slot. On any
//                earlier slot it discards the partial frame.
//   FRAME_VALID  a complete frame is presented on FRAME_DATA
//   FRAME_READY  FFT core accepts the presented frame
//   FRAME_DATA   slot k at bits [k*DATA_W +: DATA_W]; held while FRAME_VALID
//   FRAME_ERR    one-cycle pulse after an early IN_LAST
//   FILL_CNT     samples written so far into the current write bank
// ---------------------------------------------------------------------------
module fft_frame_buffer #(
    parameter int DATA_W   = 8,
    parameter int N_POINTS = 32,
    parameter int BIT_REV  = 0,
    localparam int IDX_W   = $clog2(N_POINTS)
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       IN_VALID,
    output logic                       IN_READY,
    input  logic signed [DATA_W-1:0]   IN_DATA,
    input  logic                       IN_LAST,
    output logic                       FRAME_VALID,
    input  logic                       FRAME_READY,
    output logic [N_POINTS*DATA_W-1:0] FRAME_DATA,
    output logic                       FRAME_ERR,
    output logic [IDX_W-1:0]           FILL_CNT
);

    // Store-order mapping: identity, or bit reversal over IDX_W bits.
    function automatic logic [IDX_W-1:0] slot_of(input logic [IDX_W-1:0] idx);
        logic [IDX_W-1:0] r;
        r = idx;
        if (BIT_REV != 0) begin
            for (int b = 0; b < IDX_W; b++) begin
                r[b] = idx[IDX_W-1-b];
            end
        end
        return r;
    endfunction

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    logic                                  wr_sel;
    logic                                  rd_sel;
    logic [1:0]                            full;
    logic [1:0]                            full_nxt;
    logic [IDX_W-1:0]                      wr_idx;
    logic                                  err_p1;
    logic [1:0][N_POINTS-1:0][DATA_W-1:0]  bank;

    logic accept;
    logic at_last;
    logic early_last;
    logic complete;
    logic consume;

    // Both handshakes decode only from registered state. FRAME_READY
    // therefore reaches IN_READY only through the full[] flops.
    assign IN_READY    = ~full[wr_sel];
    assign FRAME_VALID = full[rd_sel];
    assign FRAME_DATA  = bank[rd_sel];
    assign FRAME_ERR   = err_p1;
    assign FILL_CNT    = wr_idx;

    assign accept     = IN_VALID & IN_READY;
    assign at_last    = (wr_idx == LAST_IDX);
    assign early_last = accept & IN_LAST & ~at_last;
    assign complete   = accept & at_last;
    assign consume    = FRAME_VALID & FRAME_READY;

    // A completion and a consumption can share an edge. They always target
    // different banks: completion needs full[wr_sel]=0, and consumption
    // needs full[rd_sel]=1. Both updates apply independently.
    always_comb begin
        full_nxt = full;
        if (complete) full_nxt[wr_sel] = 1'b1;
        if (consume)  full_nxt[rd_sel] = 1'b0;
    end

    // ---- accept edge: write slot, advance pointers, register error pulse ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            full   <= 2'b00;
            wr_idx <= '0;
            err_p1 <= 1'b0;
            bank   <= '0;
        end else begin
            full   <= full_nxt;
            err_p1 <= early_last;

            if (consume) rd_sel <= ~rd_sel;

            if (accept) begin
                if (early_last) begin
                    // The partial frame is abandoned. The flagged sample is
                    // dropped, and stale slots are overwritten by the refill.
                    wr_idx <= '0;
                end else begin
                    bank[wr_sel][slot_of(wr_idx)] <= IN_DATA;
                    if (at_last) begin
                        wr_idx <= '0;
                        wr_sel <= ~wr_sel;
                    end else begin
                        wr_idx <= wr_idx + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_frame_buffer.sv
module tb_fft_frame_buffer;

    localparam int DW = 8;
    localparam int NP = 32;
    localparam int IW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;

    // Natural-order instance
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic signed [7:0] in_data = '0;
    logic              in_last = 1'b0;
    logic              frame_valid;
    logic              frame_ready = 1'b0;
    logic [NP*DW-1:0]  frame_data;
    logic              frame_err;
    logic [IW-1:0]     fill_cnt;

    // Bit-reversed instance
    logic              b_in_valid = 1'b0;
    logic              b_in_ready;
    logic signed [7:0] b_in_data = '0;
    logic              b_in_last = 1'b0;
    logic              b_frame_valid;
    logic              b_frame_ready = 1'b0;
    logic [NP*DW-1:0]  b_frame_data;
    logic              b_frame_err;
    logic [IW-1:0]     b_fill_cnt;

    int compared   = 0;
    int mismatched = 0;
    int gaps;

    always #5 clk = ~clk;

    fft_frame_buffer #(.DATA_W(DW), .N_POINTS(NP), .BIT_REV(0)) dut (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data), .IN_LAST(in_last),
        .FRAME_VALID(frame_valid), .FRAME_READY(frame_ready), .FRAME_DATA(frame_data),
        .FRAME_ERR(frame_err), .FILL_CNT(fill_cnt)
    );

    fft_frame_buffer #(.DATA_W(DW), .N_POINTS(NP), .BIT_REV(1)) dut_rev (
        .CLK(clk), .RST_N(rst_n),
        .IN_VALID(b_in_valid), .IN_READY(b_in_ready), .IN_DATA(b_in_data), .IN_LAST(b_in_last),
        .FRAME_VALID(b_frame_valid), .FRAME_READY(b_frame_ready), .FRAME_DATA(b_frame_data),
        .FRAME_ERR(b_frame_err), .FILL_CNT(b_fill_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slot(input logic [NP*DW-1:0] fd, input int k);
        return fd[k*DW +: DW];
    endfunction

    // Present one sample on the natural-order instance, wait (bounded) for
    // ready, and let it be accepted. IN_VALID stays high afterwards.
    task automatic send(input logic [7:0] d, input logic l);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        n = 0;
        while (!in_ready && n < 200) begin
            step();
            n++;
        end
        if (!in_ready) chk("ready_timeout", in_ready, 1);
        step();
    endtask

    initial begin
        // ---------------- reset state ----------------
        repeat (2) step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_frame_valid", frame_valid, 0);
        chk("rst_fill", fill_cnt, 0);
        chk("rst_err", frame_err, 0);
        chk("rst_data_zero", |frame_data, 0);
        rst_n = 1'b1;
        step();

        // ---------------- reset mid-frame ----------------
        for (int i = 0; i < 10; i++) send(8'(i + 1), 1'b0);
        in_valid = 1'b0;
        chk("mid_fill_before", fill_cnt, 10);
        chk("mid_data_written", slot(frame_data, 0), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_in_ready", in_ready, 1);
        chk("async_frame_valid", frame_valid, 0);
        chk("async_fill", fill_cnt, 0);
        chk("async_data_zero", |frame_data, 0);
        #1 rst_n = 1'b1;
        step();
        for (int i = 0; i < 32; i++) send(8'(i + 3), 1'b0);
        in_valid = 1'b0;
        chk("post_rst_valid", frame_valid, 1);
        chk("post_rst_slot0", slot(frame_data, 0), 3);
        chk("post_rst_slot31", slot(frame_data, 31), 34);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        chk("post_rst_drained", frame_valid, 0);

        // ---------------- ramp, back-to-back, FRAME_READY=1 ----------------
        frame_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 64; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i % 32);
            in_last  = (i % 32 == 31);
            if (!in_ready) gaps++;
            step();
            if (i == 31) begin
                chk("ramp_valid_rise", frame_valid, 1);
                chk("ramp_fill_wrap", fill_cnt, 0);
                for (int k = 0; k < NP; k++) chk($sformatf("ramp_slot%0d", k), slot(frame_data, k), k);
            end
            if (i == 32) chk("ramp_consumed", frame_valid, 0);
            if (i == 40) chk("ramp_fill9", fill_cnt, 9);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("ramp2_valid", frame_valid, 1);
        chk("ramp2_slot17", slot(frame_data, 17), 17);
        chk("ramp_no_gap", gaps, 0);
        step();
        chk("ramp2_consumed", frame_valid, 0);
        frame_ready = 1'b0;

        // ---------------- backpressure ----------------
        for (int i = 0; i < 64; i++) send(8'(i), 1'b0);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_valid", frame_valid, 1);
        in_data = 8'd64;
        repeat (3) step();
        chk("bp_stall_ready", in_ready, 0);
        chk("bp_stall_fill", fill_cnt, 0);
        for (int k = 0; k < NP; k++) chk($sformatf("bp_f1_slot%0d", k), slot(frame_data, k), k);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        chk("bp_f2_valid", frame_valid, 1);
        chk("bp_ready_back", in_ready, 1);
        chk("bp_fill_held", fill_cnt, 0);
        for (int k = 0; k < NP; k++) chk($sformatf("bp_f2_slot%0d", k), slot(frame_data, k), 32 + k);
        for (int i = 64; i < 96; i++) send(8'(i), 1'b0);
        in_valid = 1'b0;
        chk("bp_full_again", in_ready, 0);
        frame_ready = 1'b1;
        step();
        chk("bp_f3_slot0", slot(frame_data, 0), 64);
        chk("bp_f3_slot31", slot(frame_data, 31), 95);
        step();
        frame_ready = 1'b0;
        chk("bp_drained", frame_valid, 0);

        // ---------------- early IN_LAST ----------------
        for (int i = 0; i < 9; i++) send(8'(90 + i), 1'b0);
        chk("early_fill9", fill_cnt, 9);
        send(8'd77, 1'b1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("early_err_pulse", frame_err, 1);
        chk("early_fill0", fill_cnt, 0);
        chk("early_no_valid", frame_valid, 0);
        step();
        chk("early_err_drop", frame_err, 0);
        for (int i = 0; i < 32; i++) send(8'(50 + i), i == 31);
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("early_frame_valid", frame_valid, 1);
        chk("early_last_ok_err", frame_err, 0);
        chk("early_slot0", slot(frame_data, 0), 50);
        chk("early_slot9", slot(frame_data, 9), 59);
        chk("early_slot31", slot(frame_data, 31), 81);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;

        // ---------------- signed extremes + simultaneous events ----------------
        for (int i = 0; i < 32; i++) send((i % 2 == 0) ? 8'h80 : 8'h7F, 1'b0);
        for (int k = 0; k < NP; k++)
            chk($sformatf("ext_slot%0d", k), slot(frame_data, k), (k % 2 == 0) ? 32'h80 : 32'h7F);
        for (int i = 0; i < 31; i++) send(8'(-(i + 1)), 1'b0);
        chk("simul_pre_ready", in_ready, 1);
        frame_ready = 1'b1;
        send(8'(-32), 1'b1);
        frame_ready = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        chk("simul_valid", frame_valid, 1);
        chk("simul_in_ready", in_ready, 1);
        chk("simul_slot0", slot(frame_data, 0), 32'hFF);
        chk("simul_slot31", slot(frame_data, 31), 32'hE0);
        step();
        chk("simul_hold", frame_valid, 1);
        frame_ready = 1'b1;
        step();
        frame_ready = 1'b0;
        chk("simul_empty", frame_valid, 0);
        chk("simul_ready_final", in_ready, 1);

        // ---------------- bit-reversed store order ----------------
        chk("rev_idle", b_frame_valid, 0);
        for (int i = 0; i < 32; i++) begin
            b_in_valid = 1'b1;
            b_in_data  = 8'(i);
            chk($sformatf("rev_ready%0d", i), b_in_ready, 1);
            step();
        end
        b_in_valid = 1'b0;
        chk("rev_valid", b_frame_valid, 1);
        chk("rev_slot0", slot(b_frame_data, 0), 0);
        chk("rev_slot1", slot(b_frame_data, 1), 16);
        chk("rev_slot2", slot(b_frame_data, 2), 8);
        chk("rev_slot3", slot(b_frame_data, 3), 24);
        chk("rev_slot6", slot(b_frame_data, 6), 12);
        chk("rev_slot31", slot(b_frame_data, 31), 31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
